// File: rtl/demux_stream.sv
// 1-to-N stream demultiplexer with a one-entry valid/ready output register per channel.
// Optional build macro DEMUX_DROP_CNT_EN adds a saturating drop_cnt port for out-of-range selects.
module demux_stream #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e,
  input  logic [W-1:0]     i,
  input  logic [SEL_W-1:0] s,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [N*W-1:0]   y,
  output logic [N-1:0]     y_valid,
  input  logic [N-1:0]     y_ready
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  logic           w_sel_busy;
  logic           w_xfer;
  logic [N-1:0]   w_load;
  logic [N*W-1:0] r_y;
  logic [N-1:0]   r_valid;

  // Accept decision; a selected channel is only busy when full and not draining this edge
  always_comb begin
    w_sel_busy = 1'b0;
    w_load     = '0;
    for (int k = 0; k < N; k++) begin
      if (s == SEL_W'(k)) begin
        w_sel_busy = r_valid[k] & ~y_ready[k];
      end else begin
        w_sel_busy = w_sel_busy;
      end
    end
    i_ready = rst_n & e & ~w_sel_busy;
    w_xfer  = i_valid & i_ready;
    for (int k = 0; k < N; k++) begin
      w_load[k] = w_xfer & (s == SEL_W'(k));
    end
  end

  // Per-channel output registers: a load wins over a drain on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_valid <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_load[k]) begin
          r_y[k*W +: W] <= i;
          r_valid[k]    <= 1'b1;
        end else if (r_valid[k] & y_ready[k]) begin
          r_valid[k]    <= 1'b0;
        end else begin
          r_valid[k]    <= r_valid[k];
        end
      end
    end
  end

  assign y       = r_y;
  assign y_valid = r_valid;

`ifdef DEMUX_DROP_CNT_EN
  localparam logic [SEL_W:0] LP_N = (SEL_W+1)'(N);

  logic       w_drop;
  logic [7:0] r_drop_cnt;

  assign w_drop = w_xfer & ~({1'b0, s} < LP_N);

  // Saturating count of words consumed with an out-of-range select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end else begin
      r_drop_cnt <= r_drop_cnt;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Parametrised 1-to-N demultiplexer with registered outputs. It is the clocked successor to the combinational 1x2 enable demux.
- Routes a W-bit input word to one of N output channels, chosen by a select field and qualified by an enable.
- Each channel has a one-entry output register with a valid/ready handshake, so a stalled consumer does not block traffic to the other channels.
- Used wherever one producer feeds several independent consumers.

Parameters:
- W, 8, data width in bits (>=1).
- N, 4, number of output channels (2..2**SEL_W).
- SEL_W, 2, select width in bits. Requires N <= 2**SEL_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- e  input  1  enable. When low, no input is accepted.
- i  input  W  input data word.
- s  input  SEL_W  channel select.
- i_valid  input  1  input word present.
- i_ready  output  1  input word accepted this cycle.
- y  output  N*W  flat output data bus. Channel k occupies bits [k*W +: W].
- y_valid  output  N  per-channel output valid.
- y_ready  input  N  per-channel consumer ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - y_valid = 0 and y = 0 immediately, with no clock edge required.
  - If the DEMUX_DROP_CNT_EN build is used, drop_cnt = 0.
  - i_ready = 0 while reset is held.
- Release from reset is synchronous to the next rising clk edge. An in-flight word held at reset is lost with no recovery.
- Per-channel state k: one valid bit and one W-bit data register. There is no other FSM state.
  - EMPTY to FULL on a load.
  - FULL to EMPTY on drain without load.
  - FULL to FULL on simultaneous drain and load.
- Drain: on a clk edge where y_valid[k] & y_ready[k], channel k is drained.
- Accept (combinational): i_ready = rst_n & e & (s >= N | ~y_valid[s] | y_ready[s]).
  - i_ready depends combinationally on y_ready[s]. This is a deliberate pass-through that allows full throughput.
  - i_ready is independent of i_valid.
- Transfer: occurs on a clk edge where i_valid & i_ready.
  - If s < N, channel s loads i and sets y_valid[s] = 1.
  - If s >= N, the word is consumed and discarded, and no channel changes.
- Latency: a word accepted at edge t is visible on channel s after edge t, i.e. one cycle.
- Throughput: one word per cycle sustained to a channel whose consumer holds y_ready high.
- Simultaneous drain and load on the same channel at one edge: the new word replaces the old one, and y_valid stays 1.
- Channel independence: a stalled channel (y_valid = 1, y_ready = 0) blocks only inputs selected to that channel. Loads to other channels proceed.
- Stability: while y_valid[k] = 1 and y_ready[k] = 0, y[k] and y_valid[k] must hold stable.
- Ordering: strictly preserved per channel. There is no ordering guarantee across channels.
- e low: i_ready = 0 and no loads occur. Output channels still drain normally.
- Non-selected channels: keep their data register contents. Data is don't-care when y_valid[k] = 0, but the bench checks that y holds its last value.
- i, s and e are sampled only on an accepting edge. Changes while i_valid = 0 have no effect.

Optional Feature:
- Macro: DEMUX_DROP_CNT_EN.
- When defined:
  - Adds output port drop_cnt (output, 8 bits).
  - drop_cnt increments by 1 on every transfer with s >= N.
  - drop_cnt saturates at 255 and does not wrap.
  - Reset value is 0.
- When undefined:
  - The port and the counter are absent.
  - Out-of-range words are dropped silently.
  - All other behaviour is identical.
- Only meaningful when N < 2**SEL_W. With N = 2**SEL_W, drop_cnt stays 0.

Test Plan:
1. Reset mid-operation.
   - Stimulus: load channels 0 and 2, then pulse rst_n low between clock edges.
   - Response: y_valid = 0000 and y = 0 immediately, with no clock edge. After release, the first accepted word loads correctly.
2. Basic routing with W=8, N=4.
   - Stimulus: e = 1, y_ready = 1111, send (s, i) = (0, 0x11), (1, 0x22), (2, 0x33), (3, 0x44) on consecutive cycles.
   - Response: each word appears on its channel one cycle after acceptance. i_ready stays 1 throughout.
3. Backpressure isolation.
   - Stimulus: y_ready[1] = 0. Send 0xA1 to channel 1, then 0xA2 to channel 1, then 0xB0 to channel 0.
   - Response:
     - The first word is accepted.
     - For the second word, i_ready = 0 and the word is held.
     - Release y_ready[1] for one cycle: 0xA1 drains and 0xA2 loads in the same edge, with y_valid[1] staying 1.
     - 0xB0 reaches channel 0 once presented.
4. Enable gating.
   - Stimulus: e = 0, i_valid = 1, s = 2, i = 0x5C for 3 cycles, while channel 3 is full with y_ready[3] = 1.
   - Response: i_ready = 0 and no load occurs. Channel 3 still drains.
   - Stimulus: e = 1.
   - Response: 0x5C lands on channel 2 the next cycle.
5. Out-of-range select.
   - Configuration: N=3, SEL_W=2, DEMUX_DROP_CNT_EN defined.
   - Stimulus: send s = 3 300 times.
   - Response: i_ready = 1, y_valid remains 000, and drop_cnt reaches 255 and stays there.
   - Without the macro: same y behaviour, and the port is absent.
6. Random soak.
   - Stimulus: 10k cycles with random i_valid, s, e and y_ready.
   - Response: a scoreboard shows per-channel order preserved, no loss except s >= N, no duplication, and outputs stable under stall.
